ex_stage: RTL and testbench

//  Execute stage, directly downstream of the ID/EX pipeline latch. Consumes operands, rd, write flag,

---
 rtl/ex_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch/jump resolve, address gen, serial shifter, EX/MEM register
module ex_stage #(
  parameter int CMD_W        = 6,
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [31:0]      reg1_from_idex,
  input  logic [31:0]      reg2_from_idex,
  input  logic [31:0]      imm_from_idex,
  input  logic [4:0]       rsd_from_idex,
  input  logic             write_rsd_or_not_from_idex,
  input  logic [CMD_W-1:0] cmdtype_from_idex,
  input  logic [31:0]      pc_from_idex,
  input  logic             stall_in,
  output logic             stall_req,
  output logic [4:0]       rsd_to_mem,
  output logic             write_rsd_or_not_to_mem,
  output logic [31:0]      rd_data_to_mem,
  output logic [31:0]      mem_addr_to_mem,
  output logic [31:0]      store_data_to_mem,
  output logic [CMD_W-1:0] cmdtype_to_mem,
  output logic             jump_flag,
  output logic [31:0]      jump_pc
);

  localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_ADD   = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_SUB   = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_SLL   = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_SLT   = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_SLTU  = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_XOR   = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_SRL   = CMD_W'(7);
  localparam logic [CMD_W-1:0] CMD_SRA   = CMD_W'(8);
  localparam logic [CMD_W-1:0] CMD_OR    = CMD_W'(9);
  localparam logic [CMD_W-1:0] CMD_AND   = CMD_W'(10);
  localparam logic [CMD_W-1:0] CMD_ADDI  = CMD_W'(11);
  localparam logic [CMD_W-1:0] CMD_SLTI  = CMD_W'(12);
  localparam logic [CMD_W-1:0] CMD_SLTIU = CMD_W'(13);
  localparam logic [CMD_W-1:0] CMD_XORI  = CMD_W'(14);
  localparam logic [CMD_W-1:0] CMD_ORI   = CMD_W'(15);
  localparam logic [CMD_W-1:0] CMD_ANDI  = CMD_W'(16);
  localparam logic [CMD_W-1:0] CMD_SLLI  = CMD_W'(17);
  localparam logic [CMD_W-1:0] CMD_SRLI  = CMD_W'(18);
  localparam logic [CMD_W-1:0] CMD_SRAI  = CMD_W'(19);
  localparam logic [CMD_W-1:0] CMD_LUI   = CMD_W'(20);
  localparam logic [CMD_W-1:0] CMD_AUIPC = CMD_W'(21);
  localparam logic [CMD_W-1:0] CMD_JAL   = CMD_W'(22);
  localparam logic [CMD_W-1:0] CMD_JALR  = CMD_W'(23);
  localparam logic [CMD_W-1:0] CMD_BEQ   = CMD_W'(24);
  localparam logic [CMD_W-1:0] CMD_BNE   = CMD_W'(25);
  localparam logic [CMD_W-1:0] CMD_BLT   = CMD_W'(26);
  localparam logic [CMD_W-1:0] CMD_BGE   = CMD_W'(27);
  localparam logic [CMD_W-1:0] CMD_BLTU  = CMD_W'(28);
  localparam logic [CMD_W-1:0] CMD_BGEU  = CMD_W'(29);
  localparam logic [CMD_W-1:0] CMD_LB    = CMD_W'(30);
  localparam logic [CMD_W-1:0] CMD_LH    = CMD_W'(31);
  localparam logic [CMD_W-1:0] CMD_LW    = CMD_W'(32);
  localparam logic [CMD_W-1:0] CMD_LBU   = CMD_W'(33);
  localparam logic [CMD_W-1:0] CMD_LHU   = CMD_W'(34);
  localparam logic [CMD_W-1:0] CMD_SB    = CMD_W'(35);
  localparam logic [CMD_W-1:0] CMD_SH    = CMD_W'(36);
  localparam logic [CMD_W-1:0] CMD_SW    = CMD_W'(37);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d, acc_step;
  logic             jump_q;

  logic [CMD_W-1:0] cmd;
  logic [31:0]      reg1, reg2, imm, op_b;
  logic             imm_form, is_sll, is_sra, is_shift, is_load, is_store, is_branch;
  logic [4:0]       shamt;
  logic             serial_long;
  logic [31:0]      addr_sum, pc_imm, pc_4, shift_res, alu_res, result;
  logic             br_taken, jump_take, load_result, stall_busy;
  logic [31:0]      jump_target;

  function automatic logic [31:0] shift1(input logic [31:0] v, input logic left, input logic arith);
    if (left) return {v[30:0], 1'b0};
    return {arith & v[31], v[31:1]};
  endfunction

  assign cmd  = cmdtype_from_idex;
  assign reg1 = reg1_from_idex;
  assign reg2 = reg2_from_idex;
  assign imm  = imm_from_idex;

  assign imm_form  = cmd inside {CMD_ADDI, CMD_SLTI, CMD_SLTIU, CMD_XORI, CMD_ORI, CMD_ANDI,
                                 CMD_SLLI, CMD_SRLI, CMD_SRAI};
  assign is_sll    = cmd inside {CMD_SLL, CMD_SLLI};
  assign is_sra    = cmd inside {CMD_SRA, CMD_SRAI};
  assign is_shift  = cmd inside {CMD_SLL, CMD_SLLI, CMD_SRL, CMD_SRLI, CMD_SRA, CMD_SRAI};
  assign is_load   = cmd inside {CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU};
  assign is_store  = cmd inside {CMD_SB, CMD_SH, CMD_SW};
  assign is_branch = cmd inside {CMD_BEQ, CMD_BNE, CMD_BLT, CMD_BGE, CMD_BLTU, CMD_BGEU};

  assign op_b        = imm_form ? imm : reg2;
  assign shamt       = op_b[4:0];
  assign serial_long = SERIAL_SHIFT && is_shift && (shamt > 5'd1);
  assign addr_sum    = reg1 + imm;
  assign pc_imm      = pc_from_idex + imm;
  assign pc_4        = pc_from_idex + 32'd4;

  // In serial mode only 0/1-bit shifts complete here; longer ones go through the FSM.
  always_comb begin
    if (SERIAL_SHIFT)  shift_res = (shamt == 5'd0) ? reg1 : shift1(reg1, is_sll, is_sra);
    else if (is_sll)   shift_res = reg1 << shamt;
    else if (is_sra)   shift_res = $unsigned($signed(reg1) >>> shamt);
    else               shift_res = reg1 >> shamt;
  end

  always_comb begin
    alu_res = 32'd0;
    case (cmd)
      CMD_ADD, CMD_ADDI:   alu_res = reg1 + op_b;
      CMD_SUB:             alu_res = reg1 - reg2;
      CMD_SLT, CMD_SLTI:   alu_res = {31'd0, $signed(reg1) < $signed(op_b)};
      CMD_SLTU, CMD_SLTIU: alu_res = {31'd0, reg1 < op_b};
      CMD_XOR, CMD_XORI:   alu_res = reg1 ^ op_b;
      CMD_OR, CMD_ORI:     alu_res = reg1 | op_b;
      CMD_AND, CMD_ANDI:   alu_res = reg1 & op_b;
      CMD_SLL, CMD_SLLI, CMD_SRL, CMD_SRLI, CMD_SRA, CMD_SRAI: alu_res = shift_res;
      CMD_LUI:             alu_res = imm;
      CMD_AUIPC:           alu_res = pc_imm;
      CMD_JAL, CMD_JALR:   alu_res = pc_4;
      default:             alu_res = 32'd0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (cmd)
      CMD_BEQ:  br_taken = (reg1 == reg2);
      CMD_BNE:  br_taken = (reg1 != reg2);
      CMD_BLT:  br_taken = ($signed(reg1) < $signed(reg2));
      CMD_BGE:  br_taken = ($signed(reg1) >= $signed(reg2));
      CMD_BLTU: br_taken = (reg1 < reg2);
      CMD_BGEU: br_taken = (reg1 >= reg2);
      default:  br_taken = 1'b0;
    endcase
  end

  assign jump_take   = (is_branch && br_taken) || (cmd == CMD_JAL) || (cmd == CMD_JALR);
  assign jump_target = (cmd == CMD_JALR) ? (addr_sum & ~32'd1) : pc_imm;

  // The shift instruction stays on the ID/EX inputs while we are busy, so cmd still selects direction.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_step    = shift1(acc_q, is_sll, is_sra);
    result      = alu_res;
    load_result = 1'b0;
    stall_busy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (serial_long) begin
          stall_busy = 1'b1;
          state_d    = S_SHIFT;
          cnt_d      = shamt - 5'd1;
          acc_d      = shift1(reg1, is_sll, is_sra);
        end else begin
          load_result = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q > 5'd1) begin
          stall_busy = 1'b1;
          acc_d      = acc_step;
          cnt_d      = cnt_q - 5'd1;
        end else begin
          load_result = 1'b1;
          result      = acc_step;
          state_d     = S_IDLE;
          cnt_d       = 5'd0;
          acc_d       = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_req = stall_in | stall_busy;
  assign jump_flag = jump_q & ~stall_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q                 <= S_IDLE;
      cnt_q                   <= 5'd0;
      acc_q                   <= 32'd0;
      jump_q                  <= 1'b0;
      jump_pc                 <= 32'd0;
      rsd_to_mem              <= 5'd0;
      write_rsd_or_not_to_mem <= 1'b0;
      rd_data_to_mem          <= 32'd0;
      mem_addr_to_mem         <= 32'd0;
      store_data_to_mem       <= 32'd0;
      cmdtype_to_mem          <= CMD_NOP;
    end else if (!stall_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (load_result) begin
        rsd_to_mem              <= rsd_from_idex;
        write_rsd_or_not_to_mem <= write_rsd_or_not_from_idex && (rsd_from_idex != 5'd0);
        rd_data_to_mem          <= result;
        mem_addr_to_mem         <= (is_load || is_store) ? addr_sum : 32'd0;
        store_data_to_mem       <= is_store ? reg2 : 32'd0;
        cmdtype_to_mem          <= cmd;
        jump_q                  <= jump_take;
        jump_pc                 <= jump_take ? jump_target : 32'd0;
      end else begin
        rsd_to_mem              <= 5'd0;
        write_rsd_or_not_to_mem <= 1'b0;
        rd_data_to_mem          <= 32'd0;
        mem_addr_to_mem         <= 32'd0;
        store_data_to_mem       <= 32'd0;
        cmdtype_to_mem          <= CMD_NOP;
        jump_q                  <= 1'b0;
        jump_pc                 <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a transaction-level model
module tb_ex_stage;

  localparam logic [5:0] NOP = 0, ADD = 1, SUB = 2, SLL = 3, SLT = 4, SLTU = 5, XOR_ = 6, SRL = 7,
                         SRA = 8, OR_ = 9, AND_ = 10, ADDI = 11, SLTI = 12, SLTIU = 13, XORI = 14,
                         ORI = 15, ANDI = 16, SLLI = 17, SRLI = 18, SRAI = 19, LUI = 20, AUIPC = 21,
                         JAL = 22, JALR = 23, BEQ = 24, BNE = 25, BLT = 26, BGE = 27, BLTU = 28,
                         BGEU = 29, LB = 30, LH = 31, LW = 32, LBU = 33, LHU = 34, SB = 35, SH = 36,
                         SW = 37;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] reg1_from_idex, reg2_from_idex, imm_from_idex, pc_from_idex;
  logic [4:0]  rsd_from_idex;
  logic        write_rsd_or_not_from_idex;
  logic [5:0]  cmdtype_from_idex;
  logic        stall_in;
  logic        stall_req;
  logic [4:0]  rsd_to_mem;
  logic        write_rsd_or_not_to_mem;
  logic [31:0] rd_data_to_mem, mem_addr_to_mem, store_data_to_mem, jump_pc;
  logic [5:0]  cmdtype_to_mem;
  logic        jump_flag;

  int checks = 0;
  int failures = 0;

  ex_stage #(.CMD_W(6), .SERIAL_SHIFT(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .reg1_from_idex(reg1_from_idex), .reg2_from_idex(reg2_from_idex),
    .imm_from_idex(imm_from_idex), .rsd_from_idex(rsd_from_idex),
    .write_rsd_or_not_from_idex(write_rsd_or_not_from_idex),
    .cmdtype_from_idex(cmdtype_from_idex), .pc_from_idex(pc_from_idex),
    .stall_in(stall_in), .stall_req(stall_req),
    .rsd_to_mem(rsd_to_mem), .write_rsd_or_not_to_mem(write_rsd_or_not_to_mem),
    .rd_data_to_mem(rd_data_to_mem), .mem_addr_to_mem(mem_addr_to_mem),
    .store_data_to_mem(store_data_to_mem), .cmdtype_to_mem(cmdtype_to_mem),
    .jump_flag(jump_flag), .jump_pc(jump_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] rd_data;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        wr;
    logic        jf;
    logic [31:0] jpc;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_shift_op(input logic [5:0] c);
    return c inside {SLL, SRL, SRA, SLLI, SRLI, SRAI};
  endfunction

  function automatic int shift_amt(input logic [5:0] c, input logic [31:0] b, input logic [31:0] im);
    logic [31:0] v;
    v = (c inside {SLLI, SRLI, SRAI}) ? im : b;
    return int'(v[4:0]);
  endfunction

  function automatic exp_t model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] pcv,
                                 input logic [4:0] rd, input logic wr);
    exp_t e;
    int   s;
    e = '0;
    s = shift_amt(c, b, im);
    e.wr = wr && (rd != 0);
    case (c)
      ADD:   e.rd_data = a + b;
      ADDI:  e.rd_data = a + im;
      SUB:   e.rd_data = a - b;
      SLT:   e.rd_data = ($signed(a) < $signed(b)) ? 1 : 0;
      SLTI:  e.rd_data = ($signed(a) < $signed(im)) ? 1 : 0;
      SLTU:  e.rd_data = (a < b) ? 1 : 0;
      SLTIU: e.rd_data = (a < im) ? 1 : 0;
      XOR_:  e.rd_data = a ^ b;
      XORI:  e.rd_data = a ^ im;
      OR_:   e.rd_data = a | b;
      ORI:   e.rd_data = a | im;
      AND_:  e.rd_data = a & b;
      ANDI:  e.rd_data = a & im;
      SLL, SLLI: e.rd_data = a << s;
      SRL, SRLI: e.rd_data = a >> s;
      SRA, SRAI: e.rd_data = $unsigned($signed(a) >>> s);
      LUI:   e.rd_data = im;
      AUIPC: e.rd_data = pcv + im;
      JAL:   begin e.rd_data = pcv + 4; e.jf = 1; e.jpc = pcv + im; end
      JALR:  begin e.rd_data = pcv + 4; e.jf = 1; e.jpc = (a + im) & 32'hFFFF_FFFE; end
      BEQ:   e.jf = (a == b);
      BNE:   e.jf = (a != b);
      BLT:   e.jf = ($signed(a) < $signed(b));
      BGE:   e.jf = ($signed(a) >= $signed(b));
      BLTU:  e.jf = (a < b);
      BGEU:  e.jf = (a >= b);
      LB, LH, LW, LBU, LHU: e.addr = a + im;
      SB, SH, SW: begin e.addr = a + im; e.sdata = b; end
      default: ;
    endcase
    if (c inside {BEQ, BNE, BLT, BGE, BLTU, BGEU} && e.jf) e.jpc = pcv + im;
    return e;
  endfunction

  // Called right after a rising edge; issues one instruction and checks it through completion.
  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] pcv, input logic [4:0] rd,
                        input logic wr, input int stall_after);
    exp_t e;
    int   lat;
    cmdtype_from_idex = c; reg1_from_idex = a; reg2_from_idex = b; imm_from_idex = im;
    pc_from_idex = pcv; rsd_from_idex = rd; write_rsd_or_not_from_idex = wr;
    e = model(c, a, b, im, pcv, rd, wr);
    lat = (is_shift_op(c) && shift_amt(c, b, im) > 1) ? shift_amt(c, b, im) : 1;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk_in);
      check("stall_req_busy", {31'd0, stall_req}, 32'd1);
      @(posedge clk_in); #1;
      check("bubble_wr", {31'd0, write_rsd_or_not_to_mem}, 32'd0);
      check("bubble_cmd", {26'd0, cmdtype_to_mem}, 32'd0);
      if (k == stall_after) begin
        stall_in = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk_in);
          check("stall_req_ext", {31'd0, stall_req}, 32'd1);
          @(posedge clk_in); #1;
          check("frozen_wr", {31'd0, write_rsd_or_not_to_mem}, 32'd0);
          check("frozen_rd_data", rd_data_to_mem, 32'd0);
        end
        stall_in = 1'b0;
      end
    end
    @(negedge clk_in);
    check("stall_req_done", {31'd0, stall_req}, 32'd0);
    @(posedge clk_in); #1;
    check("rd_data", rd_data_to_mem, e.rd_data);
    check("write", {31'd0, write_rsd_or_not_to_mem}, {31'd0, e.wr});
    check("rsd", {27'd0, rsd_to_mem}, {27'd0, rd});
    check("cmdtype", {26'd0, cmdtype_to_mem}, {26'd0, c});
    check("mem_addr", mem_addr_to_mem, e.addr);
    check("store_data", store_data_to_mem, e.sdata);
    check("jump_flag", {31'd0, jump_flag}, {31'd0, e.jf});
    if (e.jf) check("jump_pc", jump_pc, e.jpc);
  endtask

  initial begin
    logic [5:0]  c;
    logic [31:0] a, b;
    rst_in = 1'b1; stall_in = 1'b0;
    cmdtype_from_idex = NOP; reg1_from_idex = 0; reg2_from_idex = 0; imm_from_idex = 0;
    pc_from_idex = 0; rsd_from_idex = 0; write_rsd_or_not_from_idex = 0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_rd_data", rd_data_to_mem, 32'd0);
    check("rst_write", {31'd0, write_rsd_or_not_to_mem}, 32'd0);
    check("rst_cmd", {26'd0, cmdtype_to_mem}, 32'd0);
    check("rst_jump", {31'd0, jump_flag}, 32'd0);
    check("rst_stall_req", {31'd0, stall_req}, 32'd0);
    rst_in = 1'b0;

    run_op(ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5, 1'b1, 0);
    run_op(SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd3, 1'b1, 0);
    run_op(BEQ, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h100, 5'd0, 1'b0, 0);
    check("beq_target", jump_pc, 32'hF8);
    run_op(NOP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0);
    run_op(BNE, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h100, 5'd0, 1'b0, 0);
    run_op(JALR, 32'h1003, 32'd0, 32'd0, 32'h40, 5'd1, 1'b1, 0);
    check("jalr_target", jump_pc, 32'h1002);
    check("jalr_link", rd_data_to_mem, 32'h44);
    run_op(ADDI, 32'd0, 32'd0, 32'd5, 32'd0, 5'd0, 1'b1, 0);
    run_op(SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd2, 1'b1, 0);
    run_op(SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd2, 1'b1, 0);
    run_op(SLLI, 32'h0000_0001, 32'd0, 32'd1, 32'd0, 5'd4, 1'b1, 0);
    run_op(SRLI, 32'hF000_0000, 32'd0, 32'd31, 32'd0, 5'd4, 1'b1, 0);
    run_op(SRL, 32'hDEAD_BEEF, 32'd6, 32'd0, 32'd0, 5'd7, 1'b1, 1);
    run_op(SW, 32'h1000, 32'h1234_5678, 32'hFFFF_FFFC, 32'd0, 5'd0, 1'b0, 0);

    // Taken branch followed by a MEM stall: the redirect must not be visible while stalled.
    run_op(BLT, 32'hFFFF_FFFF, 32'd1, 32'd16, 32'h200, 5'd0, 1'b0, 0);
    stall_in = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_in);
      check("stall_jump_mask", {31'd0, jump_flag}, 32'd0);
      check("stall_req_mem", {31'd0, stall_req}, 32'd1);
      @(posedge clk_in); #1;
    end
    stall_in = 1'b0;

    // Reset in the middle of a serial shift.
    cmdtype_from_idex = SLL; reg1_from_idex = 32'd1; reg2_from_idex = 32'd10;
    rsd_from_idex = 5'd9; write_rsd_or_not_from_idex = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1; cmdtype_from_idex = NOP; rsd_from_idex = 0; write_rsd_or_not_from_idex = 0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("midrst_rd_data", rd_data_to_mem, 32'd0);
    check("midrst_write", {31'd0, write_rsd_or_not_to_mem}, 32'd0);
    check("midrst_rsd", {27'd0, rsd_to_mem}, 32'd0);
    check("midrst_stall_req", {31'd0, stall_req}, 32'd0);
    run_op(ADD, 32'd3, 32'd4, 32'd0, 32'd0, 5'd8, 1'b1, 0);

    for (int n = 0; n < 150; n++) begin
      c = 6'($urandom_range(0, 37));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(c, a, b, $urandom, $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
